// File: rtl/ascii_char_buffer_pkg.sv
// Shared constants and types for the ASCII text-screen buffer.
// Grid defaults, FSM states and control-code values.
package ascii_char_buffer_pkg;

  localparam int COLS_D    = 160;
  localparam int ROWS_D    = 60;
  localparam int CW_LOG2_D = 2;
  localparam int CH_LOG2_D = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2
  } state_t;

  localparam logic [6:0] CH_BS = 7'h08;
  localparam logic [6:0] CH_LF = 7'h0A;
  localparam logic [6:0] CH_FF = 7'h0C;
  localparam logic [6:0] CH_CR = 7'h0D;
  localparam logic [6:0] CH_SP = 7'h20;
  localparam logic [6:0] CH_TL = 7'h7E;

  function automatic logic is_print(
    input logic [6:0] c
  );
    return (c >= CH_SP) && (c <= CH_TL);
  endfunction

endpackage

// File: rtl/ascii_text_ram.sv
// Character store: one write port, one registered read port.
// Contents are not reset; the owner clears them by writing spaces.
module ascii_text_ram #(
  parameter int DEPTH = 9600,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [6:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [6:0]    o_rdata
);

  logic [6:0] r_mem [DEPTH];
  logic [6:0] r_rdata;

  // read-during-write to one address returns the old contents
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ascii_char_buffer.sv
// Text-screen memory with cursor, scrolling and clear engine.
// Supplies the character under the next pixel one clock later.
module ascii_char_buffer
  import ascii_char_buffer_pkg::*;
#(
  parameter int COLS    = COLS_D,
  parameter int ROWS    = ROWS_D,
  parameter int CW_LOG2 = CW_LOG2_D,
  parameter int CH_LOG2 = CH_LOG2_D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       add_char,
  input  logic [6:0] char_value,
  output logic       ready,
  input  logic [9:0] h_counter_next,
  input  logic [9:0] v_counter_next,
  input  logic       will_display,
  output logic [6:0] char_display
);

  localparam int AW = $clog2(COLS * ROWS);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  localparam logic [CW-1:0] L_COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] L_ROW_MAX = RW'(ROWS - 1);
  localparam logic [AW-1:0] L_ALL_MAX = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] L_ROW_END = AW'(COLS - 1);

  // top_row rotates the screen; wrap with one compare/subtract
  function automatic logic [AW-1:0] f_addr(
    input int top,
    input int row,
    input int col
  );
    int p;
    p = top + row;
    if (p >= ROWS) p = p - ROWS;
    return AW'(p * COLS + col);
  endfunction

  state_t        r_state;
  state_t        w_nx_state;
  logic [CW-1:0] r_col;
  logic [CW-1:0] w_nx_col;
  logic [RW-1:0] r_row;
  logic [RW-1:0] w_nx_row;
  logic [RW-1:0] r_top;
  logic [RW-1:0] w_nx_top;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_nx_cnt;
  logic [AW-1:0] r_base;
  logic [AW-1:0] w_nx_base;
  logic          r_rd_ok;

  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [6:0]    w_wdata;
  logic          w_nl;

  logic          w_c_print;
  logic          w_c_lf;
  logic          w_c_cr;
  logic          w_c_bs;
  logic          w_c_ff;

  logic [9:0]    w_rd_col;
  logic [9:0]    w_rd_row;
  logic          w_rd_ok;
  logic [AW-1:0] w_rd_addr;
  logic [6:0]    w_ram_q;

  assign ready     = (r_state == IDLE);
  assign w_c_print = is_print(char_value);
  assign w_c_lf    = (char_value == CH_LF);
  assign w_c_cr    = (char_value == CH_CR);
  assign w_c_bs    = (char_value == CH_BS);
  assign w_c_ff    = (char_value == CH_FF);

  always_comb begin
    w_nx_state = r_state;
    w_nx_col   = r_col;
    w_nx_row   = r_row;
    w_nx_top   = r_top;
    w_nx_cnt   = r_cnt;
    w_nx_base  = r_base;
    w_we       = 1'b0;
    w_waddr    = '0;
    w_wdata    = CH_SP;
    w_nl       = 1'b0;
    unique case (r_state)
      CLR_ALL: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        if (r_cnt == L_ALL_MAX) begin
          w_nx_state = IDLE;
          w_nx_cnt   = '0;
        end else begin
          w_nx_cnt = r_cnt + AW'(1);
        end
      end
      CLR_ROW: begin
        w_we    = 1'b1;
        w_waddr = r_base + r_cnt;
        if (r_cnt == L_ROW_END) begin
          w_nx_state = IDLE;
          w_nx_cnt   = '0;
        end else begin
          w_nx_cnt = r_cnt + AW'(1);
        end
      end
      IDLE: begin
        if (add_char) begin
          unique case (1'b1)
            w_c_print: begin
              w_we    = 1'b1;
              w_waddr = f_addr(int'(r_top), int'(r_row), int'(r_col));
              w_wdata = char_value;
              if (r_col == L_COL_MAX) w_nl = 1'b1;
              else w_nx_col = r_col + CW'(1);
            end
            w_c_lf: w_nl = 1'b1;
            w_c_cr: w_nx_col = '0;
            w_c_bs: begin
              if (r_col != '0) begin
                w_nx_col = r_col - CW'(1);
                w_we     = 1'b1;
                w_waddr  = f_addr(int'(r_top), int'(r_row),
                                  int'(r_col) - 1);
              end
            end
            w_c_ff: begin
              w_nx_state = CLR_ALL;
              w_nx_cnt   = '0;
              w_nx_col   = '0;
              w_nx_row   = '0;
              w_nx_top   = '0;
            end
            default: ;
          endcase
          // scroll: oldest physical row becomes the new blank bottom row
          if (w_nl) begin
            w_nx_col = '0;
            if (r_row != L_ROW_MAX) begin
              w_nx_row = r_row + RW'(1);
            end else begin
              w_nx_top   = (r_top == L_ROW_MAX) ? '0 : r_top + RW'(1);
              w_nx_state = CLR_ROW;
              w_nx_cnt   = '0;
              w_nx_base  = f_addr(int'(r_top), 0, 0);
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLR_ALL;
      r_col   <= '0;
      r_row   <= '0;
      r_top   <= '0;
      r_cnt   <= '0;
      r_base  <= '0;
      r_rd_ok <= 1'b0;
    end else begin
      r_state <= w_nx_state;
      r_col   <= w_nx_col;
      r_row   <= w_nx_row;
      r_top   <= w_nx_top;
      r_cnt   <= w_nx_cnt;
      r_base  <= w_nx_base;
      r_rd_ok <= w_rd_ok;
    end
  end

  assign w_rd_col  = h_counter_next >> CW_LOG2;
  assign w_rd_row  = v_counter_next >> CH_LOG2;
  assign w_rd_ok   = will_display
                  && (w_rd_col < 10'(COLS))
                  && (w_rd_row < 10'(ROWS));
  assign w_rd_addr = w_rd_ok
                   ? f_addr(int'(r_top), int'(w_rd_row), int'(w_rd_col))
                   : '0;

  ascii_text_ram #(
    .DEPTH (COLS * ROWS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_q)
  );

  assign char_display = r_rd_ok ? w_ram_q : CH_SP;

endmodule

// File: tb/tb_ascii_char_buffer.sv
// Bench for ascii_char_buffer: vector table, corner sequences,
// random streams against a logical-screen model.
module tb_ascii_char_buffer;

  localparam int COLS = 160;
  localparam int ROWS = 60;
  localparam int LIM  = 20000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       add_char = 1'b0;
  logic [6:0] char_value = 7'h00;
  logic       ready;
  logic [9:0] hn = 10'd0;
  logic [9:0] vn = 10'd0;
  logic       wd = 1'b0;
  logic [6:0] cd;

  always #5 clk = ~clk;

  ascii_char_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .add_char       (add_char),
    .char_value     (char_value),
    .ready          (ready),
    .h_counter_next (hn),
    .v_counter_next (vn),
    .will_display   (wd),
    .char_display   (cd)
  );

  int total = 0;
  int bad   = 0;

  // model: logical screen (row 0 = top line shown), scrolled by copying
  int scr [ROWS][COLS];
  int mcol;
  int mrow;
  int mscroll;

  function automatic void m_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 32;
    mcol = 0;
    mrow = 0;
    mscroll = 0;
  endfunction

  function automatic void m_newline();
    mcol = 0;
    if (mrow < ROWS - 1) begin
      mrow++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 32;
      mscroll++;
    end
  endfunction

  function automatic void m_apply(int c);
    if (c >= 32 && c <= 126) begin
      scr[mrow][mcol] = c;
      if (mcol == COLS - 1) m_newline();
      else mcol++;
    end else if (c == 10) begin
      m_newline();
    end else if (c == 13) begin
      mcol = 0;
    end else if (c == 8) begin
      if (mcol > 0) begin
        mcol--;
        scr[mrow][mcol] = 32;
      end
    end else if (c == 12) begin
      m_clear();
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic send(input int c);
    int n;
    @(negedge clk);
    n = 0;
    while (!ready && n < LIM) begin
      add_char = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("send_timeout", 0, 1);
    end else begin
      add_char   = 1'b1;
      char_value = 7'(c);
      m_apply(c);
    end
  endtask

  task automatic bus_idle();
    @(negedge clk);
    add_char = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready && n < LIM);
  endtask

  // the char was presented at the last negedge; count busy cycles after it
  task automatic accept_and_count(input string name, input int exp);
    int n;
    @(posedge clk);
    #1;
    add_char = 1'b0;
    check({name, "_ready_low"}, int'(ready), 0);
    wait_ready(n);
    check(name, n, exp);
  endtask

  task automatic check_cursor(input string name);
    check({name, "_col"}, int'(dut.r_col), mcol);
    check({name, "_row"}, int'(dut.r_row), mrow);
  endtask

  // streams one read per clock; each result is checked one clock later
  task automatic scan(input int r0, input int r1, input string name);
    int nbad = 0;
    int fr = 0, fc = 0, fa = 0, fe = 0;
    int pr = 0, pc = 0;
    bit first = 1'b1;
    for (int r = r0; r <= r1; r++) begin
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk);
        add_char = 1'b0;
        if (!first && int'(cd) != scr[pr][pc]) begin
          if (nbad == 0) begin
            fr = pr; fc = pc; fa = int'(cd); fe = scr[pr][pc];
          end
          nbad++;
        end
        hn = 10'(c * 4 + int'($urandom_range(3)));
        vn = 10'(r * 8 + int'($urandom_range(7)));
        wd = 1'b1;
        pr = r;
        pc = c;
        first = 1'b0;
      end
    end
    @(negedge clk);
    if (int'(cd) != scr[pr][pc]) begin
      if (nbad == 0) begin
        fr = pr; fc = pc; fa = int'(cd); fe = scr[pr][pc];
      end
      nbad++;
    end
    wd = 1'b0;
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL %s: %0d cells wrong, first (%0d,%0d) got 0x%0h want 0x%0h",
               name, nbad, fc, fr, fa, fe);
    end
  endtask

  typedef struct {
    int    h;
    int    v;
    bit    wd;
    int    exp;
    string name;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int n;
    int junk [8];
    tbl[0]  = '{0,    0,    1'b1, 8'h48, "rd_c0"};
    tbl[1]  = '{4,    0,    1'b1, 8'h69, "rd_c1"};
    tbl[2]  = '{3,    7,    1'b1, 8'h48, "rd_c0_edge"};
    tbl[3]  = '{7,    5,    1'b1, 8'h69, "rd_c1_edge"};
    tbl[4]  = '{8,    0,    1'b1, 8'h20, "rd_c2"};
    tbl[5]  = '{4,    0,    1'b0, 8'h20, "rd_blank"};
    tbl[6]  = '{640,  0,    1'b1, 8'h20, "rd_col_oob"};
    tbl[7]  = '{0,    0,    1'b1, 8'h48, "rd_c0_again"};
    tbl[8]  = '{0,    480,  1'b1, 8'h20, "rd_row_oob"};
    tbl[9]  = '{4,    8,    1'b1, 8'h20, "rd_row1"};
    tbl[10] = '{1023, 1023, 1'b1, 8'h20, "rd_far_oob"};
    tbl[11] = '{636,  472,  1'b1, 8'h20, "rd_last_cell"};
    junk[0] = 0;  junk[1] = 7;  junk[2] = 9;   junk[3] = 27;
    junk[4] = 31; junk[5] = 1;  junk[6] = 127; junk[7] = 11;

    // reset state and power-up clear
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(ready), 0);
    check("rst_disp", int'(cd), 32);
    check("rst_col", int'(dut.r_col), 0);
    check("rst_row", int'(dut.r_row), 0);
    check("rst_top", int'(dut.r_top), 0);
    @(negedge clk);
    reset = 1'b0;
    m_clear();
    wait_ready(n);
    check("init_clear_cycles", n, COLS * ROWS);
    scan(0, ROWS - 1, "init_blank");

    // two characters and the read-path vector table
    send(8'h48);
    send(8'h69);
    bus_idle();
    check_cursor("hi");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      hn = 10'(tbl[i].h);
      vn = 10'(tbl[i].v);
      wd = tbl[i].wd;
      @(negedge clk);
      check(tbl[i].name, int'(cd), tbl[i].exp);
    end
    wd = 1'b0;

    // full row wraps onto the next
    send(13);
    for (int i = 0; i < COLS; i++) send(8'h41);
    send(8'h42);
    bus_idle();
    check_cursor("wrap");
    scan(0, 1, "wrap_rows");

    // backspace, backspace at column 0, ignored codes
    send(13);
    send(8'h58);
    send(8);
    bus_idle();
    check_cursor("bs");
    send(8);
    send(7);
    send(127);
    send(0);
    bus_idle();
    check_cursor("bs_col0_ignored");
    scan(0, 1, "bs_rows");

    // random stream (no form feed)
    for (int i = 0; i < 700; i++) begin
      int r;
      int c;
      r = int'($urandom_range(99));
      if (r < 70)      c = int'($urandom_range(32, 126));
      else if (r < 79) c = 10;
      else if (r < 84) c = 13;
      else if (r < 92) c = 8;
      else             c = junk[$urandom_range(7)];
      send(c);
    end
    bus_idle();
    check_cursor("rand");
    check("rand_top", int'(dut.r_top), mscroll % ROWS);
    scan(0, ROWS - 1, "rand_screen");

    // form feed, then fill every row and scroll once
    send(12);
    accept_and_count("ff_cycles", COLS * ROWS);
    check_cursor("ff");
    check("ff_top", int'(dut.r_top), 0);
    for (int r = 0; r < ROWS; r++) begin
      send(8'h61 + r % 26);
      send(8'h30 + r % 10);
      if (r < ROWS - 1) send(10);
    end
    send(10);
    accept_and_count("scroll_cycles", COLS);
    check("scroll_top", int'(dut.r_top), 1);
    check_cursor("scroll");
    scan(0, 1, "scroll_top_rows");
    scan(ROWS - 2, ROWS - 1, "scroll_bottom_rows");

    // reset while a row clear is in progress
    send(10);
    @(posedge clk);
    #1;
    add_char = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_clrrow_col", int'(dut.r_col), 0);
    check("rst_clrrow_row", int'(dut.r_row), 0);
    check("rst_clrrow_top", int'(dut.r_top), 0);
    check("rst_clrrow_ready", int'(ready), 0);
    @(negedge clk);
    reset = 1'b0;
    m_clear();

    // reset again mid power-up clear, with a char held while busy
    repeat (3000) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    add_char = 1'b1;
    char_value = 7'h5A;
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n);
    add_char = 1'b0;
    check("rst_clrall_cycles", n, COLS * ROWS);
    check("held_col", int'(dut.r_col), 0);
    check("held_row", int'(dut.r_row), 0);
    scan(0, 1, "after_resets");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
